dmem_ctrl: RTL and testbench



---
 rtl/dmem_ctrl.sv | 147 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Byte-lane data memory behind a valid/ready request/response front end.
module dmem_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IW;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic                  we_p0;
  logic                  err_p0;
  logic                  uns_p0;
  logic [1:0]            size_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [31:0]           wdata_p0;
  logic [IW-1:0]         raddr_p1;
  logic                  req_err;
  logic                  accept;
  logic                  wr_en;
  logic [3:0]            be;
  logic [31:0]           wrep;
  logic [31:0]           rd_word;

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] size,
                                           input logic uns, input logic [1:0] off);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   r = uns ? {24'd0, b} : 32'(b);
      2'b01:   r = uns ? {16'd0, h} : 32'(h);
      default: r = w;
    endcase
    return r;
  endfunction

  always_comb begin
    req_err = (req_size == 2'b11)
           || (req_size == 2'b01 && req_addr[0])
           || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
           || ((req_addr >> ADDR_WIDTH) != 32'd0);
  end

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid && req_ready;

  // Stage p0: request capture and sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      we_p0  <= 1'b0;
      err_p0 <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          we_p0  <= req_we;
          err_p0 <= req_err;
          cnt    <= '0;
          state  <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end
        S_WAIT: begin
          if (cnt == WAIT_LAST) begin
            cnt   <= '0;
            state <= S_ACCESS;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_ACCESS: state <= S_RESP;
        default:  if (rsp_ready) state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      uns_p0   <= req_unsigned;
      size_p0  <= req_size;
      addr_p0  <= req_addr[ADDR_WIDTH-1:0];
      wdata_p0 <= req_wdata;
    end
  end

  // Stage p1: memory access, read address registered for BRAM inference
  always_ff @(posedge clk) begin
    if (state == S_ACCESS && !we_p0 && !err_p0) raddr_p1 <= addr_p0[ADDR_WIDTH-1:2];
  end

  always_comb begin
    be   = 4'b0000;
    wrep = wdata_p0;
    case (size_p0)
      2'b00: begin
        be   = 4'b0001 << addr_p0[1:0];
        wrep = {4{wdata_p0[7:0]}};
      end
      2'b01: begin
        be   = addr_p0[1] ? 4'b1100 : 4'b0011;
        wrep = {2{wdata_p0[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign wr_en = (state == S_ACCESS) && we_p0 && !err_p0;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] lane [DEPTH];
    always_ff @(posedge clk) begin
      if (wr_en && be[i]) lane[addr_p0[ADDR_WIDTH-1:2]] <= wrep[8*i +: 8];
    end
    assign rd_word[8*i +: 8] = lane[raddr_p1];
  end

  // Stage p2: response formatting, zero outside a successful load
  assign rsp_valid = (state == S_RESP);
  assign rsp_err   = (state == S_RESP) && err_p0;
  assign rsp_rdata = (state == S_RESP && !we_p0 && !err_p0)
                   ? fmt_load(rd_word, size_p0, uns_p0, addr_p0[1:0]) : 32'd0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: table of accesses plus stall, reset and wait-state sequences.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0, rsp_rdata;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err;

  logic        w_req_valid = 1'b0, w_req_ready, w_req_we = 1'b0, w_req_unsigned = 1'b0;
  logic [1:0]  w_req_size = 2'd2;
  logic [31:0] w_req_addr = '0, w_req_wdata = '0, w_rsp_rdata;
  logic        w_rsp_valid, w_rsp_ready = 1'b1, w_rsp_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc[$];
  logic [31:0] w_last_rdata = '0;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_WIDTH(16), .WAIT_CYCLES(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_ctrl #(.ADDR_WIDTH(16), .WAIT_CYCLES(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .req_valid(w_req_valid), .req_ready(w_req_ready),
    .req_we(w_req_we), .req_size(w_req_size), .req_unsigned(w_req_unsigned),
    .req_addr(w_req_addr), .req_wdata(w_req_wdata), .rsp_valid(w_rsp_valid),
    .rsp_ready(w_rsp_ready), .rsp_rdata(w_rsp_rdata), .rsp_err(w_rsp_err)
  );

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (w_req_valid && w_req_ready) acc_cyc.push_back(cyc);
  always @(posedge clk) if (w_rsp_valid && w_rsp_ready) w_last_rdata <= w_rsp_rdata;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    if (!rsp_valid) lat = -1;
    rdata = rsp_rdata;
    err = rsp_err;
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h100,      32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h100,      32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h102,      32'hFFFFFF55, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 2'd2, 1'b0, 32'h100,      32'h0,        32'hDE55BEEF, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 32'h103,      32'h0,        32'hFFFFFFDE, 1'b0};
    vecs[5]  = '{1'b0, 2'd0, 1'b1, 32'h103,      32'h0,        32'h000000DE, 1'b0};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h100,      32'h0,        32'hFFFFBEEF, 1'b0};
    vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h102,      32'h0,        32'h0000DE55, 1'b0};
    vecs[8]  = '{1'b0, 2'd0, 1'b0, 32'h102,      32'h0,        32'h00000055, 1'b0};
    vecs[9]  = '{1'b0, 2'd0, 1'b1, 32'h100,      32'h0,        32'h000000EF, 1'b0};
    vecs[10] = '{1'b0, 2'd0, 1'b0, 32'h101,      32'h0,        32'hFFFFFFBE, 1'b0};
    vecs[11] = '{1'b1, 2'd1, 1'b0, 32'h106,      32'h12348001, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 2'd1, 1'b0, 32'h106,      32'h0,        32'hFFFF8001, 1'b0};
    vecs[13] = '{1'b0, 2'd1, 1'b1, 32'h106,      32'h0,        32'h00008001, 1'b0};
    vecs[14] = '{1'b1, 2'd2, 1'b0, 32'h101,      32'h11111111, 32'h0,        1'b1};
    vecs[15] = '{1'b0, 2'd1, 1'b0, 32'h103,      32'h0,        32'h0,        1'b1};
    vecs[16] = '{1'b0, 2'd3, 1'b0, 32'h100,      32'h0,        32'h0,        1'b1};
    vecs[17] = '{1'b0, 2'd2, 1'b0, 32'h00010000, 32'h0,        32'h0,        1'b1};
    vecs[18] = '{1'b1, 2'd2, 1'b0, 32'h00010100, 32'h22222222, 32'h0,        1'b1};
    vecs[19] = '{1'b1, 2'd3, 1'b0, 32'h100,      32'h0,        32'h0,        1'b1};
    vecs[20] = '{1'b0, 2'd2, 1'b1, 32'h100,      32'h0,        32'hDE55BEEF, 1'b0};
    vecs[21] = '{1'b1, 2'd2, 1'b0, 32'h200,      32'h0,        32'h0,        1'b0};
    vecs[22] = '{1'b0, 2'd2, 1'b0, 32'h200,      32'h0,        32'h0,        1'b0};

    // reset state
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      txn(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd1);
    end

    // response held while the consumer stalls; a request pulse is ignored
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h100;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk("stall_lat", 32'(n), 32'd1);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h100; req_wdata = 32'h0;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("stall%0d_valid", k), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("stall%0d_rdata", k), rsp_rdata, 32'hDE55BEEF);
      chk($sformatf("stall%0d_err", k), {31'd0, rsp_err}, 32'd0);
      chk($sformatf("stall%0d_req_ready", k), {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_stall_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_stall_rdata", rsp_rdata, 32'd0);
    chk("post_stall_ready", {31'd0, req_ready}, 32'd1);
    txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rd, er, lat);
    chk("post_stall_load", rd, 32'hDE55BEEF);

    // reset during ACCESS of a store suppresses the write
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h200; req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid_busy", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_mid_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    txn(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, rd, er, lat);
    chk("rst_mid_load", rd, 32'd0);
    chk("rst_mid_load_err", {31'd0, er}, 32'd0);

    // two wait states: latency and back-to-back throughput
    @(negedge clk);
    w_req_valid = 1'b1; w_req_we = 1'b1; w_req_size = 2'd2; w_req_addr = 32'h10; w_req_wdata = 32'hCAFEF00D;
    n = 0;
    while (!w_req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    w_req_valid = 1'b0;
    n = 0;
    while (!w_rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk("wait2_lat", 32'(n), 32'd3);
    chk("wait2_store_err", {31'd0, w_rsp_err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    acc_cyc.delete();
    w_req_valid = 1'b1; w_req_we = 1'b0; w_req_size = 2'd2; w_req_addr = 32'h10;
    repeat (17) @(negedge clk);
    w_req_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("wait2_accepts", 32'(acc_cyc.size()), 32'd4);
    if (acc_cyc.size() >= 3) begin
      chk("wait2_gap0", 32'(acc_cyc[1] - acc_cyc[0]), 32'd5);
      chk("wait2_gap1", 32'(acc_cyc[2] - acc_cyc[1]), 32'd5);
    end
    chk("wait2_load", w_last_rdata, 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
